// File: rtl/mamba_pkg.sv
// Shared types and helpers for the Mamba datapath blocks: tile geometry,
// lane vector type and the lane-to-line packing used by the buffer writers.
package mamba_pkg;

    localparam int TILE_SIZE  = 4;
    localparam int DATA_WIDTH = 16;
    localparam int LINE_W     = TILE_SIZE * DATA_WIDTH;

    typedef logic signed [TILE_SIZE-1:0][DATA_WIDTH-1:0] tile_vec_t;
    typedef logic [LINE_W-1:0]                          line_t;

    typedef enum logic {
        WB_IDLE,
        WB_RUN
    } wb_state_e;

    // Lane 0 lands in the LSBs; values are copied bit-exact.
    function automatic line_t pack_tile(input tile_vec_t v);
        line_t l;
        l = '0;
        for (int i = 0; i < TILE_SIZE; i++) begin
            l[i*DATA_WIDTH +: DATA_WIDTH] = v[i];
        end
        return l;
    endfunction

endpackage

// File: rtl/s_state_writeback_if.sv
// Tile input stream plus state-buffer write port of the state writeback block.
interface s_state_writeback_if #(
    parameter int S_ADDR_W = 6
);
    import mamba_pkg::*;

    logic                s_in_valid;
    logic                s_in_ready;
    tile_vec_t           s_in_vec;
    logic                mem_wr_en;
    logic [S_ADDR_W-1:0] mem_wr_addr;
    line_t               mem_wr_data;
    logic                mem_wr_ready;

    // Writeback block side.
    modport slave (
        input  s_in_valid, s_in_vec, mem_wr_ready,
        output s_in_ready, mem_wr_en, mem_wr_addr, mem_wr_data
    );

    // Tile source / memory side.
    modport master (
        output s_in_valid, s_in_vec, mem_wr_ready,
        input  s_in_ready, mem_wr_en, mem_wr_addr, mem_wr_data
    );

endinterface

// File: rtl/s_state_writeback.sv
// State writeback: accepts N_TILES tiles per frame from the EW stage, packs
// each into one line and writes it to the state buffer at a wrapping,
// auto-incrementing address starting from base_addr.
module s_state_writeback
    import mamba_pkg::*;
#(
    parameter  int D        = 256,
    parameter  int S_ADDR_W = 6,
    localparam int N_TILES  = D / TILE_SIZE,
    localparam int CNT_W    = $clog2(N_TILES + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [S_ADDR_W-1:0] base_addr,
    s_state_writeback_if.slave  wb,
    output logic                busy,
    output logic                frame_done,
    output logic [CNT_W-1:0]    tile_cnt,
    output logic                err_start_busy
);

    wb_state_e           state_q, state_d;
    logic [S_ADDR_W-1:0] wr_addr;
    logic [CNT_W-1:0]    acc_cnt;
    logic                wr_en_q;
    logic [S_ADDR_W-1:0] wr_addr_q;
    line_t               wr_data_q;

    logic rdy, accept, wr_done, last_wr, start_ok, start_err;

    assign wr_done        = wr_en_q && wb.mem_wr_ready;
    assign accept         = wb.s_in_valid && rdy;
    assign wb.s_in_ready  = rdy;
    assign wb.mem_wr_en   = wr_en_q;
    assign wb.mem_wr_addr = wr_addr_q;
    assign wb.mem_wr_data = wr_data_q;
    assign busy           = (state_q == WB_RUN);

    // Next-state and handshake decode; the write register may drain and
    // refill in the same cycle so a full frame streams at one tile per clock.
    always_comb begin
        state_d   = state_q;
        rdy       = 1'b0;
        last_wr   = 1'b0;
        start_ok  = 1'b0;
        start_err = 1'b0;
        case (state_q)
            WB_IDLE: begin
                if (start) begin
                    start_ok = 1'b1;
                    state_d  = WB_RUN;
                end
            end
            WB_RUN: begin
                start_err = start;
                rdy       = (acc_cnt < CNT_W'(N_TILES)) && (!wr_en_q || wb.mem_wr_ready);
                last_wr   = wr_done && (tile_cnt == CNT_W'(N_TILES - 1));
                if (last_wr) state_d = WB_IDLE;
            end
            default: state_d = WB_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= WB_IDLE;
        else     state_q <= state_d;
    end

    // Frame address/counters, completion pulse and sticky start error.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_addr        <= '0;
            acc_cnt        <= '0;
            tile_cnt       <= '0;
            frame_done     <= 1'b0;
            err_start_busy <= 1'b0;
        end else begin
            frame_done     <= last_wr;
            err_start_busy <= err_start_busy | start_err;
            if (start_ok) begin
                wr_addr  <= base_addr;
                acc_cnt  <= '0;
                tile_cnt <= '0;
            end else begin
                if (accept) begin
                    wr_addr <= wr_addr + 1'b1;
                    acc_cnt <= acc_cnt + 1'b1;
                end
                if (wr_done) tile_cnt <= tile_cnt + 1'b1;
            end
        end
    end

    // Single write register; addr/data only change on a new accept, so they
    // hold while memory stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else if (accept) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= wr_addr;
            wr_data_q <= pack_tile(wb.s_in_vec);
        end else if (wr_done) begin
            wr_en_q   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_s_state_writeback.sv
// Directed bench for s_state_writeback: frames with full throughput,
// memory backpressure, address wrap, overflow stall, start-in-RUN and
// mid-frame reset, all checked against a tile scoreboard.
module tb_s_state_writeback;
    import mamba_pkg::*;

    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst, start;
    logic [AW-1:0] base_addr;
    logic          busy, frame_done, err_start_busy;
    logic [6:0]    tile_cnt;

    s_state_writeback_if #(.S_ADDR_W(AW)) wb();

    s_state_writeback #(.D(256), .S_ADDR_W(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .base_addr      (base_addr),
        .wb             (wb),
        .busy           (busy),
        .frame_done     (frame_done),
        .tile_cnt       (tile_cnt),
        .err_start_busy (err_start_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [63:0]   d;
    } wr_t;

    wr_t           q[$];
    int            n_tests, n_fail;
    int            src_idx, src_end, cyc, n_acc, n_wr, n_done, mode, first_c, last_c;
    bit            rst_r, start_r, rdy_mode, acc_prev, stall_prev, done_exp;
    logic [AW-1:0] base_r, exp_addr, last_a, prev_a;
    logic [63:0]   last_d, prev_d;
    logic [3:0]    pat = 4'b1001;   // ready pattern 1,0,0,1 by cycle index

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Test tile a: lanes {4a+1,4a+2,4a+3,4a+4}<<8, truncated to 16 bits.
    function automatic logic [63:0] tile(input int a);
        logic [63:0] d;
        for (int k = 0; k < 4; k++) d[16*k +: 16] = 16'((4*a + k + 1) << 8);
        return d;
    endfunction

    task automatic step();
        wr_t  e;
        logic comp, acc;
        @(negedge clk);
        rst             = rst_r;
        start           = start_r;
        base_addr       = base_r;
        wb.s_in_valid   = (src_idx < src_end);
        wb.s_in_vec     = tile(src_idx);
        wb.mem_wr_ready = rdy_mode ? pat[cyc % 4] : 1'b1;
        #1;
        if (acc_prev) begin
            chk("lat_en", wb.mem_wr_en, 1);
            chk("lat_addr", wb.mem_wr_addr, last_a);
            chk("lat_data", wb.mem_wr_data, last_d);
        end
        if (stall_prev) begin
            chk("stall_en", wb.mem_wr_en, 1);
            chk("stall_addr", wb.mem_wr_addr, prev_a);
            chk("stall_data", wb.mem_wr_data, prev_d);
        end
        if (done_exp) begin
            chk("done_pulse", frame_done, 1);
            chk("done_busy", busy, 0);
            chk("done_cnt", tile_cnt, 64);
        end
        if (frame_done) n_done++;
        if (wb.mem_wr_en && !wb.mem_wr_ready) chk("bp_ready", wb.s_in_ready, 0);
        if (busy && n_acc >= 64) chk("ovf_ready", wb.s_in_ready, 0);
        comp     = wb.mem_wr_en && wb.mem_wr_ready && !rst_r;
        acc      = wb.s_in_valid && wb.s_in_ready && !rst_r;
        done_exp = 1'b0;
        if (comp) begin
            if (q.size() == 0) chk("wr_extra", 1, 0);
            else begin
                e = q.pop_front();
                chk("wr_addr", wb.mem_wr_addr, e.a);
                chk("wr_data", wb.mem_wr_data, e.d);
                if (mode == 1 && e.a == 5) chk("addr5_data", wb.mem_wr_data, 64'h1800_1700_1600_1500);
                if (mode == 3 && wb.mem_wr_addr == 0) chk("wrap_data0", wb.mem_wr_data, tile(4));
                if (mode == 5 && n_wr == 0) begin
                    chk("ovf_carry_addr", wb.mem_wr_addr, 10);
                    chk("ovf_carry_data", wb.mem_wr_data, tile(64));
                end
            end
            if (n_wr == 0)  first_c = cyc;
            if (n_wr == 63) last_c  = cyc;
            n_wr++;
            if (n_wr == 64) done_exp = 1'b1;
        end
        if (acc) begin
            e.a = exp_addr;
            e.d = tile(src_idx);
            q.push_back(e);
            last_a = e.a;
            last_d = e.d;
            exp_addr++;
            src_idx++;
            n_acc++;
        end
        acc_prev   = acc;
        stall_prev = wb.mem_wr_en && !wb.mem_wr_ready && !rst_r;
        prev_a     = wb.mem_wr_addr;
        prev_d     = wb.mem_wr_data;
        cyc++;
    endtask

    task automatic begin_frame(input logic [AW-1:0] base);
        exp_addr = base;
        n_acc    = 0;
        n_wr     = 0;
        start_r  = 1'b1;
        base_r   = base;
        step();
        start_r  = 1'b0;
        step();
        chk("start_busy", busy, 1);
    endtask

    task automatic run_frame(input bit mid_start);
        int d0, c;
        bit fired;
        d0    = n_done;
        c     = 0;
        fired = 1'b0;
        while (n_done == d0 && c < 600) begin
            if (mid_start && !fired && n_acc == 10) begin
                start_r = 1'b1;
                base_r  = 33;
                fired   = 1'b1;
            end
            step();
            start_r = 1'b0;
            c++;
        end
        chk("frame_timeout", c < 600, 1);
        chk("acc_cnt", n_acc, 64);
        chk("wr_cnt", n_wr, 64);
        chk("q_empty", q.size(), 0);
        repeat (3) step();
        chk("one_done", n_done - d0, 1);
        chk("tile_cnt_hold", tile_cnt, 64);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        int c;
        n_tests = 0; n_fail = 0; cyc = 0; n_done = 0; mode = 0;
        src_idx = 0; src_end = 0; n_acc = 0; n_wr = 0;
        rst_r = 1'b1; start_r = 1'b0; base_r = '0; rdy_mode = 1'b0; exp_addr = '0;

        // Reset state
        step(); step();
        chk("rst_ready", wb.s_in_ready, 0);
        chk("rst_en", wb.mem_wr_en, 0);
        chk("rst_addr", wb.mem_wr_addr, 0);
        chk("rst_data", wb.mem_wr_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_cnt", tile_cnt, 0);
        chk("rst_err", err_start_busy, 0);
        rst_r = 1'b0;
        step();

        // Basic frame, full throughput
        mode = 1; src_idx = 0; src_end = 64;
        begin_frame(0);
        run_frame(0);
        chk("throughput", last_c - first_c, 63);
        chk("basic_err", err_start_busy, 0);

        // Memory backpressure 1,0,0,1
        mode = 2; rdy_mode = 1'b1; src_idx = 0; src_end = 64;
        begin_frame(0);
        run_frame(0);
        rdy_mode = 1'b0;

        // Address wrap from 60
        mode = 3; src_idx = 0; src_end = 64;
        begin_frame(60);
        run_frame(0);

        // Overflow: 70 tiles offered, 64 taken, tile 64 carried to next frame
        mode = 4; src_idx = 0; src_end = 70;
        begin_frame(0);
        run_frame(0);
        chk("ovf_accepted", src_idx, 64);
        mode = 5; src_end = 128;
        begin_frame(10);
        run_frame(0);

        // Start while running: ignored, sticky error
        mode = 6; src_idx = 0; src_end = 64;
        begin_frame(0);
        run_frame(1);
        chk("err_set", err_start_busy, 1);
        step();
        chk("err_sticky", err_start_busy, 1);

        // Reset mid-frame with a write pending
        mode = 7; src_idx = 0; src_end = 64;
        begin_frame(0);
        c = 0;
        while (n_wr < 20 && c < 200) begin step(); c++; end
        chk("mid_reach20", n_wr, 20);
        chk("mid_pending", wb.mem_wr_en, 1);
        rst_r = 1'b1;
        step();
        rst_r = 1'b0;
        step();
        chk("mid_rst_en", wb.mem_wr_en, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cnt", tile_cnt, 0);
        chk("mid_rst_err", err_start_busy, 0);
        q.delete();
        src_idx = 0; src_end = 64;
        begin_frame(0);
        run_frame(0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
